rom_byte_loader: RTL and testbench

// - Downstream leaf of the bridge address decoder for the ROM window (0x00000000-0x000FFFFF).
// - Accepts 32-bit bridge writes without backpressure and buffers them in a word FIFO.
// - Serialises each word into four byte writes on a byte-wide ROM write port.
// - Exposes load status (byte count, busy, sticky errors) on bridge reads.

---
 rtl/rom_byte_loader_if.sv | 25 ++
 rtl/rom_byte_loader.sv | 154 +++++++++++++++
 tb/tb_rom_byte_loader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rom_byte_loader_if.sv
// Bridge write/read strobes and the byte-wide ROM write port of the ROM loader.
// master = bridge/ROM environment side, slave = the loader.
interface rom_byte_loader_if #(
   parameter int ROM_AW = 20
);
   logic              bridge_wr;
   logic              bridge_rd;
   logic [31:0]       bridge_addr;
   logic [31:0]       bridge_wr_data;
   logic [31:0]       bridge_rd_data;
   logic              rom_we;
   logic [ROM_AW-1:0] rom_addr;
   logic [7:0]        rom_wdata;
   logic              rom_ready;

   modport master (
      output bridge_wr, bridge_rd, bridge_addr, bridge_wr_data, rom_ready,
      input  bridge_rd_data, rom_we, rom_addr, rom_wdata
   );

   modport slave (
      input  bridge_wr, bridge_rd, bridge_addr, bridge_wr_data, rom_ready,
      output bridge_rd_data, rom_we, rom_addr, rom_wdata
   );
endinterface

// File: rtl/rom_byte_loader.sv
// ROM window loader: buffers 32-bit bridge writes in a word FIFO and serialises
// each word MSB-first into four byte writes, with status readable over the bridge.
module rom_byte_loader #(
   parameter logic [31:0] ROM_BYTES  = 32'h0010_0000,
   parameter int          ROM_AW     = 20,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                  clk_74a,
   input  logic                  reset,
   input  logic                  load_start,
   rom_byte_loader_if.slave      bus,
   output logic                  busy,
   output logic [20:0]           byte_count
);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int WA_W    = ROM_AW - 2;
   localparam int ENTRY_W = WA_W + 32;

   typedef enum logic {S_IDLE, S_BYTE} state_e;

   state_e             state_q, state_d;
   logic [1:0]         idx_q, idx_d;
   logic [31:0]        shift_q, shift_d;
   logic [WA_W-1:0]    word_addr_q, word_addr_d;
   logic [20:0]        count_q, count_d;
   logic               overflow_q, overflow_d;
   logic               oob_q, oob_d;
   logic [31:0]        rd_data_q, rd_data_d;
   logic               busy_q, busy_d;
   logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
   logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];

   logic               push, pop, empty, full, in_range;
   logic [ENTRY_W-1:0] head;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign head     = fifo_mem[rd_ptr_q[PTR_W-1:0]];
   assign in_range = (bus.bridge_addr < ROM_BYTES);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latches are inferred.
      state_d     = state_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      word_addr_d = word_addr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      oob_d       = oob_q;
      rd_data_d   = rd_data_q;
      push        = 1'b0;
      pop         = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop         = 1'b1;
               shift_d     = head[31:0];
               word_addr_d = head[ENTRY_W-1:32];
               idx_d       = 2'd0;
               state_d     = S_BYTE;
            end
         end
         S_BYTE: begin
            if (bus.rom_ready) begin
               shift_d = {shift_q[23:0], 8'h00};
               idx_d   = idx_q + 2'd1;
               if (count_q != '1) count_d = count_q + 21'd1;
               if (idx_q == 2'd3) begin
                  // Chain straight into the next word so there is no idle bubble.
                  if (!empty) begin
                     pop         = 1'b1;
                     shift_d     = head[31:0];
                     word_addr_d = head[ENTRY_W-1:32];
                     idx_d       = 2'd0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
      endcase

      if (bus.bridge_wr) begin
         if (!in_range)          oob_d      = 1'b1;
         else if (!full || pop)  push       = 1'b1;
         else                    overflow_d = 1'b1;
      end

      // Status is captured from current registers, so a same-cycle write is not visible.
      if (bus.bridge_rd) rd_data_d = {busy_q, overflow_q, oob_q, 8'h00, count_q};

      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);

      if (load_start) begin
         state_d     = S_IDLE;
         idx_d       = '0;
         shift_d     = '0;
         word_addr_d = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         oob_d       = 1'b0;
         rd_data_d   = '0;
         push        = 1'b0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
      end

      busy_d = (wr_ptr_d != rd_ptr_d) || (state_d == S_BYTE);
   end

   always_ff @(posedge clk_74a) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         shift_q     <= '0;
         word_addr_q <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         oob_q       <= 1'b0;
         rd_data_q   <= '0;
         busy_q      <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         word_addr_q <= word_addr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         oob_q       <= oob_d;
         rd_data_q   <= rd_data_d;
         busy_q      <= busy_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
      end
   end

   // NOTE: FIFO storage has no reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk_74a) begin
      if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {bus.bridge_addr[ROM_AW-1:2], bus.bridge_wr_data};
   end

   assign bus.rom_we         = (state_q == S_BYTE);
   assign bus.rom_addr       = {word_addr_q, idx_q};
   assign bus.rom_wdata      = shift_q[31:24];
   assign bus.bridge_rd_data = rd_data_q;
   assign busy               = busy_q;
   assign byte_count         = count_q;
endmodule

// File: tb/tb_rom_byte_loader.sv
// Directed bench for rom_byte_loader: vector table for the basic flows, plus
// hand-written stall, overflow and mid-word abort sequences.
module tb_rom_byte_loader;
   logic        clk_74a = 1'b0;
   logic        reset;
   logic        load_start;
   logic        busy;
   logic [20:0] byte_count;
   int          errors = 0;
   int          checks = 0;

   rom_byte_loader_if #(.ROM_AW(20)) bus ();

   rom_byte_loader #(
      .ROM_BYTES (32'h0010_0000),
      .ROM_AW    (20),
      .FIFO_DEPTH(4)
   ) dut (
      .clk_74a   (clk_74a),
      .reset     (reset),
      .load_start(load_start),
      .bus       (bus),
      .busy      (busy),
      .byte_count(byte_count)
   );

   always #5 clk_74a = ~clk_74a;

   typedef struct {
      logic        ls, wr, rd;
      logic [31:0] addr, data;
      logic        exp_we;
      logic [19:0] exp_addr;
      logic [7:0]  exp_wdata;
      logic        exp_busy;
      logic [20:0] exp_cnt;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[26];

   function automatic vec_t mk(input logic ls, wr, rd, input logic [31:0] addr, data,
                               input logic we, input logic [19:0] ea, input logic [7:0] ed,
                               input logic eb, input logic [20:0] ec, input logic [31:0] er);
      vec_t v;
      v.ls = ls; v.wr = wr; v.rd = rd; v.addr = addr; v.data = data;
      v.exp_we = we; v.exp_addr = ea; v.exp_wdata = ed;
      v.exp_busy = eb; v.exp_cnt = ec; v.exp_rd = er;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_74a);
      #1;
   endtask

   task automatic check_rom(input string tag, input logic we, input logic [19:0] a,
                            input logic [7:0] d);
      check({tag, ".we"}, 32'(bus.rom_we), 32'(we));
      if (we) begin
         check({tag, ".addr"}, 32'(bus.rom_addr), 32'(a));
         check({tag, ".wdata"}, 32'(bus.rom_wdata), 32'(d));
      end
   endtask

   task automatic do_read(input string tag, input logic [31:0] exp);
      bus.bridge_rd = 1'b1;
      tick();
      bus.bridge_rd = 1'b0;
      check({tag, ".rd_data"}, bus.bridge_rd_data, exp);
   endtask

   initial begin
      reset              = 1'b1;
      load_start         = 1'b0;
      bus.bridge_wr      = 1'b0;
      bus.bridge_rd      = 1'b0;
      bus.bridge_addr    = '0;
      bus.bridge_wr_data = '0;
      bus.rom_ready      = 1'b1;

      //                ls wr rd addr          data          we addr     d      busy cnt  rd
      vecs[0]  = mk(0, 1, 0, 32'h0010_0000, 32'hDEADBEEF, 0, 20'h0,   8'h00, 0,   0,  32'h0);
      vecs[1]  = mk(0, 0, 1, 32'h0,         32'h0,        0, 20'h0,   8'h00, 0,   0,  32'h2000_0000);
      vecs[2]  = mk(1, 0, 0, 32'h0,         32'h0,        0, 20'h0,   8'h00, 0,   0,  32'h0);
      vecs[3]  = mk(0, 1, 0, 32'h0,         32'h11223344, 0, 20'h0,   8'h00, 1,   0,  32'h0);
      vecs[4]  = mk(0, 0, 0, 32'h0,         32'h0,        1, 20'h000, 8'h11, 1,   0,  32'h0);
      vecs[5]  = mk(0, 0, 0, 32'h0,         32'h0,        1, 20'h001, 8'h22, 1,   1,  32'h0);
      vecs[6]  = mk(0, 0, 0, 32'h0,         32'h0,        1, 20'h002, 8'h33, 1,   2,  32'h0);
      vecs[7]  = mk(0, 0, 0, 32'h0,         32'h0,        1, 20'h003, 8'h44, 1,   3,  32'h0);
      vecs[8]  = mk(0, 0, 0, 32'h0,         32'h0,        0, 20'h0,   8'h00, 0,   4,  32'h0);
      vecs[9]  = mk(0, 0, 1, 32'h0,         32'h0,        0, 20'h0,   8'h00, 0,   4,  32'h4);
      vecs[10] = mk(0, 1, 0, 32'h10,        32'hA1A2A3A4, 0, 20'h0,   8'h00, 1,   4,  32'h4);
      vecs[11] = mk(0, 1, 0, 32'h14,        32'hB1B2B3B4, 1, 20'h010, 8'hA1, 1,   4,  32'h4);
      vecs[12] = mk(0, 0, 0, 32'h0,         32'h0,        1, 20'h011, 8'hA2, 1,   5,  32'h4);
      vecs[13] = mk(0, 0, 0, 32'h0,         32'h0,        1, 20'h012, 8'hA3, 1,   6,  32'h4);
      vecs[14] = mk(0, 0, 0, 32'h0,         32'h0,        1, 20'h013, 8'hA4, 1,   7,  32'h4);
      vecs[15] = mk(0, 0, 0, 32'h0,         32'h0,        1, 20'h014, 8'hB1, 1,   8,  32'h4);
      vecs[16] = mk(0, 0, 0, 32'h0,         32'h0,        1, 20'h015, 8'hB2, 1,   9,  32'h4);
      vecs[17] = mk(0, 0, 0, 32'h0,         32'h0,        1, 20'h016, 8'hB3, 1,  10,  32'h4);
      vecs[18] = mk(0, 0, 0, 32'h0,         32'h0,        1, 20'h017, 8'hB4, 1,  11,  32'h4);
      vecs[19] = mk(0, 0, 0, 32'h0,         32'h0,        0, 20'h0,   8'h00, 0,  12,  32'h4);
      vecs[20] = mk(0, 1, 1, 32'h20,        32'hC1C2C3C4, 0, 20'h0,   8'h00, 1,  12,  32'hC);
      vecs[21] = mk(0, 0, 0, 32'h0,         32'h0,        1, 20'h020, 8'hC1, 1,  12,  32'hC);
      vecs[22] = mk(0, 0, 0, 32'h0,         32'h0,        1, 20'h021, 8'hC2, 1,  13,  32'hC);
      vecs[23] = mk(0, 0, 0, 32'h0,         32'h0,        1, 20'h022, 8'hC3, 1,  14,  32'hC);
      vecs[24] = mk(0, 0, 0, 32'h0,         32'h0,        1, 20'h023, 8'hC4, 1,  15,  32'hC);
      vecs[25] = mk(0, 0, 0, 32'h0,         32'h0,        0, 20'h0,   8'h00, 0,  16,  32'hC);

      tick();
      tick();
      reset = 1'b0;
      check("reset.rd_data", bus.bridge_rd_data, 32'h0);
      check("reset.we",      32'(bus.rom_we),    32'h0);
      check("reset.addr",    32'(bus.rom_addr),  32'h0);
      check("reset.wdata",   32'(bus.rom_wdata), 32'h0);
      check("reset.busy",    32'(busy),          32'h0);
      check("reset.count",   32'(byte_count),    32'h0);

      for (int i = 0; i < 26; i++) begin
         load_start         = vecs[i].ls;
         bus.bridge_wr      = vecs[i].wr;
         bus.bridge_rd      = vecs[i].rd;
         bus.bridge_addr    = vecs[i].addr;
         bus.bridge_wr_data = vecs[i].data;
         tick();
         check_rom($sformatf("v%0d", i), vecs[i].exp_we, vecs[i].exp_addr, vecs[i].exp_wdata);
         check($sformatf("v%0d.busy", i),    32'(busy),          32'(vecs[i].exp_busy));
         check($sformatf("v%0d.count", i),   32'(byte_count),    32'(vecs[i].exp_cnt));
         check($sformatf("v%0d.rd_data", i), bus.bridge_rd_data, vecs[i].exp_rd);
      end
      load_start    = 1'b0;
      bus.bridge_wr = 1'b0;
      bus.bridge_rd = 1'b0;

      // rom_ready toggled 1-0-1 in the middle of a word
      bus.bridge_wr      = 1'b1;
      bus.bridge_addr    = 32'h40;
      bus.bridge_wr_data = 32'h55667788;
      tick();
      bus.bridge_wr = 1'b0;
      tick();
      check_rom("stall.b0", 1'b1, 20'h040, 8'h55);
      check("stall.b0.count", 32'(byte_count), 32'd16);
      tick();
      check_rom("stall.b1", 1'b1, 20'h041, 8'h66);
      bus.rom_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_rom($sformatf("stall.hold%0d", i), 1'b1, 20'h041, 8'h66);
         check($sformatf("stall.hold%0d.count", i), 32'(byte_count), 32'd17);
      end
      bus.rom_ready = 1'b1;
      tick();
      check_rom("stall.b2", 1'b1, 20'h042, 8'h77);
      tick();
      check_rom("stall.b3", 1'b1, 20'h043, 8'h88);
      tick();
      check_rom("stall.end", 1'b0, 20'h0, 8'h00);
      check("stall.end.count", 32'(byte_count), 32'd20);
      check("stall.end.busy",  32'(busy),       32'd0);

      // Eight writes while the ROM is stalled: one word in the serialiser, four queued
      load_start = 1'b1;
      tick();
      load_start    = 1'b0;
      bus.rom_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.bridge_wr      = 1'b1;
         bus.bridge_addr    = 32'h100 + 32'(4 * i);
         bus.bridge_wr_data = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
         tick();
      end
      bus.bridge_wr = 1'b0;
      check_rom("ovf.stalled", 1'b1, 20'h100, 8'h00);
      check("ovf.stalled.count", 32'(byte_count), 32'd0);
      do_read("ovf.pre", 32'hC000_0000);
      bus.rom_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         check_rom($sformatf("ovf.byte%0d", k), 1'b1, 20'h100 + 20'(k), 8'(k));
         tick();
      end
      check_rom("ovf.end", 1'b0, 20'h0, 8'h00);
      check("ovf.end.busy",  32'(busy),       32'd0);
      check("ovf.end.count", 32'(byte_count), 32'd20);
      do_read("ovf.post", 32'h4000_0014);

      // load_start while byte 2 of a word is out and two words are queued
      load_start = 1'b1;
      tick();
      load_start         = 1'b0;
      bus.bridge_wr      = 1'b1;
      bus.bridge_addr    = 32'h0010_0000;
      bus.bridge_wr_data = 32'h0;
      tick();
      for (int i = 0; i < 3; i++) begin
         bus.bridge_addr    = 32'h200 + 32'(4 * i);
         bus.bridge_wr_data = 32'hA0A1A2A3 + 32'(i);
         tick();
      end
      bus.bridge_wr = 1'b0;
      tick();
      check_rom("abort.idx2", 1'b1, 20'h202, 8'hA2);
      check("abort.idx2.count", 32'(byte_count), 32'd2);
      load_start         = 1'b1;
      bus.bridge_wr      = 1'b1;
      bus.bridge_addr    = 32'h300;
      bus.bridge_wr_data = 32'h12345678;
      tick();
      load_start    = 1'b0;
      bus.bridge_wr = 1'b0;
      check("abort.count", 32'(byte_count), 32'd0);
      check("abort.busy",  32'(busy),       32'd0);
      for (int i = 0; i < 3; i++) begin
         check_rom($sformatf("abort.quiet%0d", i), 1'b0, 20'h0, 8'h00);
         tick();
      end
      do_read("abort.status", 32'h0);
      load_start         = 1'b1;
      bus.bridge_wr      = 1'b1;
      bus.bridge_addr    = 32'h0010_0000;
      tick();
      load_start    = 1'b0;
      bus.bridge_wr = 1'b0;
      do_read("abort.oob_dropped", 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
